// File: rtl/brushless_commutator_pkg.sv
// -----------------------------------------------------------------------------
// brushless_commutator_pkg
// Shared types and helpers for the three-phase commutator:
//   - ctrlState_e  : OFF / RUN / BRAKE controller state
//   - phaseDrive_e : FLOAT / HI / LO / BRK per-phase drive request
//   - phaseSet_t   : drive request for all three phases {grn, ylw, blu}
//   - gatePair_t   : {high, low} gate request pair for one phase
//   - hallValid()  : rejects the two impossible hall codes (000, 111)
//   - hallDecode() : six-step hall code to phase drive table
//   - phaseGates() : phase drive plus PWM level to gate pair
// -----------------------------------------------------------------------------
package brushless_commutator_pkg;

    localparam int PWM_W_DEFAULT = 11;
    localparam int PWM_PERIOD    = 2 ** PWM_W_DEFAULT;

    typedef enum logic [1:0] {
        CTRL_OFF   = 2'd0,
        CTRL_RUN   = 2'd1,
        CTRL_BRAKE = 2'd2
    } ctrlState_e;

    typedef enum logic [1:0] {
        PH_FLOAT = 2'd0,
        PH_HI    = 2'd1,
        PH_LO    = 2'd2,
        PH_BRK   = 2'd3
    } phaseDrive_e;

    typedef struct packed {
        phaseDrive_e grn;
        phaseDrive_e ylw;
        phaseDrive_e blu;
    } phaseSet_t;

    typedef struct packed {
        logic high;
        logic low;
    } gatePair_t;

    function automatic logic hallValid(input logic [2:0] hall);
        return (hall != 3'b000) && (hall != 3'b111);
    endfunction

    // hall is {Grn, Ylw, Blu}; invalid codes leave every phase floating.
    function automatic phaseSet_t hallDecode(input logic [2:0] hall);
        phaseSet_t ps;
        ps = '{PH_FLOAT, PH_FLOAT, PH_FLOAT};
        case (hall)
            3'b101:  ps = '{PH_HI,    PH_LO,    PH_FLOAT};
            3'b100:  ps = '{PH_HI,    PH_FLOAT, PH_LO};
            3'b110:  ps = '{PH_FLOAT, PH_HI,    PH_LO};
            3'b010:  ps = '{PH_LO,    PH_HI,    PH_FLOAT};
            3'b011:  ps = '{PH_LO,    PH_FLOAT, PH_HI};
            3'b001:  ps = '{PH_FLOAT, PH_LO,    PH_HI};
            default: ps = '{PH_FLOAT, PH_FLOAT, PH_FLOAT};
        endcase
        return ps;
    endfunction

    // HI chops the high side with pwm, LO chops the low side; the
    // complementary switch fills the off-time (synchronous rectification).
    function automatic gatePair_t phaseGates(input phaseDrive_e drv, input logic pwm);
        gatePair_t g;
        case (drv)
            PH_HI:   g = '{high: pwm,  low: ~pwm};
            PH_LO:   g = '{high: ~pwm, low: pwm};
            PH_BRK:  g = '{high: 1'b0, low: 1'b1};
            default: g = '{high: 1'b0, low: 1'b0};
        endcase
        return g;
    endfunction

endpackage

// File: rtl/brushless_commutator_if.sv
// -----------------------------------------------------------------------------
// brushless_commutator_if
// Control/sensor inputs and gate-request outputs of the commutator.
//   en, brake, duty          : drive controls from the motor controller
//   hallGrn/Ylw/Blu          : raw asynchronous hall sensor levels
//   highX/lowX (X=Grn,Ylw,Blu): gate requests to the nonoverlap stages
//   pwm_synch                : one-clock mid-period strobe for the ADC
//   hall_err                 : sticky invalid-hall flag
// master = controller side (drives inputs), slave = commutator side.
// -----------------------------------------------------------------------------
interface brushless_commutator_if
    import brushless_commutator_pkg::*;
#(
    parameter int PWM_W = PWM_W_DEFAULT
) ();

    logic             en;
    logic             brake;
    logic [PWM_W-1:0] duty;
    logic             hallGrn;
    logic             hallYlw;
    logic             hallBlu;
    logic             highGrn;
    logic             lowGrn;
    logic             highYlw;
    logic             lowYlw;
    logic             highBlu;
    logic             lowBlu;
    logic             pwm_synch;
    logic             hall_err;

    modport master (
        output en, brake, duty, hallGrn, hallYlw, hallBlu,
        input  highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_synch, hall_err
    );

    modport slave (
        input  en, brake, duty, hallGrn, hallYlw, hallBlu,
        output highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_synch, hall_err
    );

endinterface

// File: rtl/brushless_commutator_pwm_gen.sv
// -----------------------------------------------------------------------------
// brushless_commutator_pwm_gen
// Free-running 2**PWM_W period counter with a per-period duty latch.
//   clk, rst   : clock, synchronous active-high reset
//   duty       : requested high time in clocks, sampled only at the boundary
//   pwm        : cnt < latched duty (combinational)
//   boundary   : high while cnt is at its last value; the next edge wraps it
//   midPeriod  : high while cnt is at half period
// -----------------------------------------------------------------------------
module brushless_commutator_pwm_gen
    import brushless_commutator_pkg::*;
#(
    parameter int PWM_W = PWM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm,
    output logic             boundary,
    output logic             midPeriod
);

    localparam logic [PWM_W-1:0] CNT_LAST = '1;
    localparam logic [PWM_W-1:0] CNT_MID  = {1'b1, {(PWM_W-1){1'b0}}};

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] dutyLat;

    // NOTE: reset is synchronous (sampled on the clock edge like any other
    // input); every state element uses <= so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            dutyLat <= '0;
        end else begin
            cnt <= cnt + PWM_W'(1);
            if (boundary) begin
                dutyLat <= duty;
            end
        end
    end

    assign boundary  = (cnt == CNT_LAST);
    assign midPeriod = (cnt == CNT_MID);
    // Strict compare: duty 0 never high, full-scale duty leaves one low clock.
    assign pwm       = (cnt < dutyLat);

endmodule

// File: rtl/brushless_commutator.sv
// -----------------------------------------------------------------------------
// brushless_commutator
// Six-step commutation of a three-phase bridge from hall sensors.
//   clk, rst : clock, synchronous active-high reset
//   bus      : brushless_commutator_if.slave (controls, halls, gate requests,
//              pwm_synch, hall_err)
// Halls are double-flopped, then hall code, duty and controller state are
// all captured together at the period boundary so one PWM period always
// runs with one consistent commutation step. All outputs are registered.
// -----------------------------------------------------------------------------
module brushless_commutator
    import brushless_commutator_pkg::*;
#(
    parameter int PWM_W = PWM_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    brushless_commutator_if.slave  bus
);

    logic       pwm;
    logic       boundary;
    logic       midPeriod;

    logic [2:0] hallMeta;
    logic [2:0] hallSync;
    logic [2:0] hallLat;

    ctrlState_e state;
    ctrlState_e stateNext;
    logic       hallErr;
    logic       hallErrNext;

    phaseSet_t  drive;
    gatePair_t  gGrn;
    gatePair_t  gYlw;
    gatePair_t  gBlu;
    logic [5:0] gateQ;
    logic       synchQ;

    brushless_commutator_pwm_gen #(
        .PWM_W     (PWM_W)
    ) u_pwm_gen (
        .clk       (clk),
        .rst       (rst),
        .duty      (bus.duty),
        .pwm       (pwm),
        .boundary  (boundary),
        .midPeriod (midPeriod)
    );

    // Two-flop synchronizer, then per-period hall capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            hallMeta <= '0;
            hallSync <= '0;
            hallLat  <= '0;
        end else begin
            hallMeta <= {bus.hallGrn, bus.hallYlw, bus.hallBlu};
            hallSync <= hallMeta;
            if (boundary) begin
                hallLat <= hallSync;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CTRL_OFF;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        stateNext   = state;
        hallErrNext = hallErr;
        if (boundary) begin
            if (!bus.en) begin
                // Going OFF clears the error even if the hall code is bad.
                stateNext   = CTRL_OFF;
                hallErrNext = 1'b0;
            end else if (bus.brake) begin
                stateNext = CTRL_BRAKE;
            end else begin
                stateNext = CTRL_RUN;
                // hallSync is what hallLat becomes at this same edge.
                if (!hallValid(hallSync)) begin
                    hallErrNext = 1'b1;
                end
            end
        end

        drive = '{PH_FLOAT, PH_FLOAT, PH_FLOAT};
        case (state)
            CTRL_RUN:   drive = hallDecode(hallLat);
            CTRL_BRAKE: drive = '{PH_BRK, PH_BRK, PH_BRK};
            default:    drive = '{PH_FLOAT, PH_FLOAT, PH_FLOAT};
        endcase

        gGrn = phaseGates(drive.grn, pwm);
        gYlw = phaseGates(drive.ylw, pwm);
        gBlu = phaseGates(drive.blu, pwm);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gateQ   <= '0;
            synchQ  <= 1'b0;
            hallErr <= 1'b0;
        end else begin
            gateQ   <= {gGrn, gYlw, gBlu};
            synchQ  <= midPeriod;
            hallErr <= hallErrNext;
        end
    end

    assign bus.highGrn   = gateQ[5];
    assign bus.lowGrn    = gateQ[4];
    assign bus.highYlw   = gateQ[3];
    assign bus.lowYlw    = gateQ[2];
    assign bus.highBlu   = gateQ[1];
    assign bus.lowBlu    = gateQ[0];
    assign bus.pwm_synch = synchQ;
    assign bus.hall_err  = hallErr;

endmodule

// File: tb/tb_brushless_commutator.sv
// -----------------------------------------------------------------------------
// tb_brushless_commutator
// Directed stimulus in one initial block; for every PWM period the expected
// per-output high-clock counts, sync position and error flag are pushed to a
// scoreboard queue, and a period monitor pops and compares them once the
// DUT has produced that period's outputs.
// -----------------------------------------------------------------------------
module tb_brushless_commutator;
    import brushless_commutator_pkg::*;

    typedef struct packed {
        int   hg;
        int   lg;
        int   hy;
        int   ly;
        int   hb;
        int   lb;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   monGo = 1'b0;
    int   tbCnt = 0;
    int   checkCount = 0;
    int   errorCount = 0;
    exp_t scoreQ[$];

    logic [2:0] hallTab[5] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    int         dutyTab[5] = '{0, 2047, 700, 1, 1500};
    string      patTab[5]  = '{"HFL", "FHL", "LHF", "LFH", "FLH"};

    brushless_commutator_if bus ();

    brushless_commutator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected counter value after each edge; used only to place stimulus.
    always @(posedge clk) begin
        if (rst) tbCnt <= 0;
        else     tbCnt <= (tbCnt == PWM_PERIOD - 1) ? 0 : tbCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // pat is three letters {Grn,Ylw,Blu}: F float, H high-chop, L low-chop, B brake.
    function automatic exp_t makeExp(input string pat, input int d, input logic err);
        exp_t e;
        int   hi[3];
        int   lo[3];
        for (int p = 0; p < 3; p++) begin
            case (pat[p])
                "H":     begin hi[p] = d;              lo[p] = PWM_PERIOD - d; end
                "L":     begin hi[p] = PWM_PERIOD - d; lo[p] = d;              end
                "B":     begin hi[p] = 0;              lo[p] = PWM_PERIOD;     end
                default: begin hi[p] = 0;              lo[p] = 0;              end
            endcase
        end
        e = '{hg: hi[0], lg: lo[0], hy: hi[1], ly: lo[1], hb: hi[2], lb: lo[2], err: err};
        return e;
    endfunction

    task automatic pushExp(input string pat, input int d, input logic err);
        scoreQ.push_back(makeExp(pat, d, err));
    endtask

    task automatic setHall(input logic [2:0] h);
        {bus.hallGrn, bus.hallYlw, bus.hallBlu} = h;
    endtask

    // Advance at least one negedge, stop at the next negedge where tbCnt == c.
    task automatic waitCnt(input int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tbCnt != c && n < 2 * PWM_PERIOD);
    endtask

    task automatic nextPeriodAt(input int c);
        waitCnt(0);
        if (c != 0) waitCnt(c);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_highGrn"}, bus.highGrn, 0);
        check({tag, "_lowGrn"}, bus.lowGrn, 0);
        check({tag, "_highYlw"}, bus.highYlw, 0);
        check({tag, "_lowYlw"}, bus.lowYlw, 0);
        check({tag, "_highBlu"}, bus.highBlu, 0);
        check({tag, "_lowBlu"}, bus.lowBlu, 0);
        check({tag, "_pwm_synch"}, bus.pwm_synch, 0);
        check({tag, "_hall_err"}, bus.hall_err, 0);
    endtask

    // Period monitor: window k covers the 2048 samples taken after edges
    // 2048k+1 .. 2048k+2048 counted from the last reset edge.
    initial begin
        int   win = 0;
        int   c[6];
        int   syncCnt;
        int   syncPos;
        int   overlap;
        logic errObs;
        exp_t e;
        wait (monGo);
        forever begin
            for (int i = 0; i < 6; i++) c[i] = 0;
            syncCnt = 0;
            syncPos = -1;
            overlap = 0;
            errObs  = 1'b0;
            for (int j = 0; j < PWM_PERIOD; j++) begin
                @(negedge clk);
                if (j == 0) errObs = bus.hall_err;
                c[0] += int'(bus.highGrn);
                c[1] += int'(bus.lowGrn);
                c[2] += int'(bus.highYlw);
                c[3] += int'(bus.lowYlw);
                c[4] += int'(bus.highBlu);
                c[5] += int'(bus.lowBlu);
                if ((bus.highGrn & bus.lowGrn) | (bus.highYlw & bus.lowYlw) |
                    (bus.highBlu & bus.lowBlu)) overlap++;
                if (bus.pwm_synch) begin
                    syncCnt++;
                    syncPos = j;
                end
            end
            check($sformatf("w%0d_scoreboard_nonempty", win), 32'(scoreQ.size() > 0), 1);
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                check($sformatf("w%0d_highGrn_clks", win), c[0], e.hg);
                check($sformatf("w%0d_lowGrn_clks", win), c[1], e.lg);
                check($sformatf("w%0d_highYlw_clks", win), c[2], e.hy);
                check($sformatf("w%0d_lowYlw_clks", win), c[3], e.ly);
                check($sformatf("w%0d_highBlu_clks", win), c[4], e.hb);
                check($sformatf("w%0d_lowBlu_clks", win), c[5], e.lb);
                check($sformatf("w%0d_hall_err", win), errObs, e.err);
                check($sformatf("w%0d_overlap", win), overlap, 0);
                check($sformatf("w%0d_sync_count", win), syncCnt, 1);
                check($sformatf("w%0d_sync_pos", win), syncPos, PWM_PERIOD / 2);
            end
            win++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en    = 1'b1;
        bus.brake = 1'b0;
        bus.duty  = 11'd512;
        setHall(3'b111);

        // Power-on reset.
        repeat (3) @(negedge clk);
        checkAllZero("por");
        rst = 1'b0;

        // Boundary 1: RUN with invalid hall -> floating outputs, error set.
        nextPeriodAt(100);
        check("pre_err_set", bus.hall_err, 1);
        check("pre_float_highGrn", bus.highGrn, 0);
        check("pre_float_lowGrn", bus.lowGrn, 0);
        setHall(3'b101);

        // Boundary 2: hall 101, duty 512, at cnt 599 pwm is low.
        nextPeriodAt(600);
        check("pre_run_highGrn", bus.highGrn, 0);
        check("pre_run_lowGrn", bus.lowGrn, 1);
        check("pre_run_highYlw", bus.highYlw, 1);
        check("pre_run_lowYlw", bus.lowYlw, 0);
        check("pre_run_err_sticky", bus.hall_err, 1);

        // Mid-run reset held for three edges.
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("rst_edge1");
        repeat (2) @(negedge clk);
        checkAllZero("rst_edge3");
        rst   = 1'b0;
        monGo = 1'b1;

        pushExp("FFF", 0, 1'b0);        // W0: OFF after reset
        pushExp("HLF", 512, 1'b0);      // W1

        // Duty change mid-period takes effect one period later.
        nextPeriodAt(300);
        bus.duty = 11'd1024;
        pushExp("HLF", 1024, 1'b0);     // W2

        // Hall steps (with duty edge cases) changed mid-period.
        for (int i = 0; i < 5; i++) begin
            nextPeriodAt(1000);
            setHall(hallTab[i]);
            bus.duty = 11'(dutyTab[i]);
            pushExp(patTab[i], dutyTab[i], 1'b0);   // W3..W7
        end

        // Change one clock before boundary: deferred a period.
        nextPeriodAt(2046);
        setHall(3'b101);
        pushExp("FLH", 1500, 1'b0);     // W8
        nextPeriodAt(1000);
        pushExp("HLF", 1500, 1'b0);     // W9

        // Change two clocks before boundary: captured.
        nextPeriodAt(2045);
        setHall(3'b110);
        pushExp("FHL", 1500, 1'b0);     // W10

        // Invalid hall sets sticky error; valid hall does not clear it.
        nextPeriodAt(1000);
        setHall(3'b111);
        pushExp("FFF", 1500, 1'b1);     // W11
        nextPeriodAt(1000);
        setHall(3'b101);
        pushExp("HLF", 1500, 1'b1);     // W12

        // en=0 clears it even with an invalid hall at the same boundary.
        nextPeriodAt(1000);
        bus.en = 1'b0;
        setHall(3'b000);
        pushExp("FFF", 1500, 1'b0);     // W13
        nextPeriodAt(1000);
        bus.en = 1'b1;
        setHall(3'b101);
        pushExp("HLF", 1500, 1'b0);     // W14

        // Brake, release, then en low wins over brake.
        nextPeriodAt(1000);
        bus.brake = 1'b1;
        pushExp("BBB", 1500, 1'b0);     // W15
        nextPeriodAt(1000);
        bus.brake = 1'b0;
        pushExp("HLF", 1500, 1'b0);     // W16
        nextPeriodAt(1000);
        bus.en    = 1'b0;
        bus.brake = 1'b1;
        pushExp("FFF", 1500, 1'b0);     // W17

        for (int n = 0; n < 4 * PWM_PERIOD && scoreQ.size() > 0; n++) @(negedge clk);
        check("scoreboard_drained", scoreQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
